// File: rtl/eth_rx_hdr_parser.sv
// Ethernet RX header parser: strips the 14-byte header and re-aligns payload to byte 0.
// Define ETH_RX_HDR_PARSER_STATS_EN to build the frame/runt statistics counters.
module eth_rx_hdr_parser #(
  parameter int DATA_W     = 256,
  parameter int PADBYTES_W = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mac_engine_rx_val,
  output logic                  engine_mac_rx_rdy,
  input  logic [DATA_W-1:0]     mac_engine_rx_data,
  input  logic                  mac_engine_rx_last,
  input  logic [PADBYTES_W-1:0] mac_engine_rx_padbytes,
  output logic                  eth_hdr_val,
  input  logic                  eth_hdr_rdy,
  output logic [47:0]           eth_dst_mac,
  output logic [47:0]           eth_src_mac,
  output logic [15:0]           eth_type,
  output logic                  eth_data_val,
  input  logic                  eth_data_rdy,
  output logic [DATA_W-1:0]     eth_data,
  output logic                  eth_data_last,
  output logic [PADBYTES_W-1:0] eth_data_padbytes,
  output logic [31:0]           stat_frame_cnt,
  output logic [31:0]           stat_runt_cnt
);
  localparam int B      = DATA_W/8;
  localparam int HDR_W  = 112;
  localparam int HOLD_W = DATA_W - HDR_W;
  localparam int VW     = PADBYTES_W + 1;

  typedef enum logic [1:0] {HDR, PAYLOAD, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold;
  logic [PADBYTES_W-1:0] tail, tail_nxt;
  logic [VW-1:0]         v;
  logic                  short_last, hdr_load, hold_load;

  assign v          = mac_engine_rx_last ? VW'(B) - VW'(mac_engine_rx_padbytes) : VW'(B);
  assign short_last = mac_engine_rx_last && (v <= VW'(14));

  always_comb begin
    state_nxt         = state;
    tail_nxt          = tail;
    hdr_load          = 1'b0;
    hold_load         = 1'b0;
    engine_mac_rx_rdy = 1'b0;
    eth_data_val      = 1'b0;
    eth_data          = '0;
    eth_data_last     = 1'b0;
    eth_data_padbytes = '0;
    unique case (state)
      HDR: begin
        engine_mac_rx_rdy = ~eth_hdr_val | eth_hdr_rdy;
        if (mac_engine_rx_val && engine_mac_rx_rdy && !short_last) begin
          hdr_load  = 1'b1;
          hold_load = 1'b1;
          if (mac_engine_rx_last) begin
            state_nxt = FLUSH;
            tail_nxt  = PADBYTES_W'(v - VW'(14));
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // output beat = 18 held bytes of the previous beat + first 14 bytes of this one
        eth_data_val      = mac_engine_rx_val;
        eth_data          = {hold, mac_engine_rx_data[DATA_W-1 -: HDR_W]};
        engine_mac_rx_rdy = eth_data_rdy;
        if (short_last) begin
          eth_data_last     = 1'b1;
          eth_data_padbytes = PADBYTES_W'(VW'(14) - v);
        end
        if (mac_engine_rx_val && eth_data_rdy) begin
          if (short_last) begin
            state_nxt = HDR;
          end else begin
            hold_load = 1'b1;
            if (mac_engine_rx_last) begin
              state_nxt = FLUSH;
              tail_nxt  = PADBYTES_W'(v - VW'(14));
            end
          end
        end
      end
      FLUSH: begin
        eth_data_val      = 1'b1;
        eth_data          = {hold, {HDR_W{1'b0}}};
        eth_data_last     = 1'b1;
        eth_data_padbytes = PADBYTES_W'(VW'(B) - VW'(tail));
        if (eth_data_rdy) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR;
      tail        <= '0;
      hold        <= '0;
      eth_hdr_val <= 1'b0;
      eth_dst_mac <= '0;
      eth_src_mac <= '0;
      eth_type    <= '0;
    end else begin
      state <= state_nxt;
      tail  <= tail_nxt;
      if (hold_load) hold <= mac_engine_rx_data[HOLD_W-1:0];
      // a new first beat may reload the header in the cycle the old one is dequeued
      if (hdr_load) begin
        eth_hdr_val <= 1'b1;
        eth_dst_mac <= mac_engine_rx_data[DATA_W-1  -: 48];
        eth_src_mac <= mac_engine_rx_data[DATA_W-49 -: 48];
        eth_type    <= mac_engine_rx_data[DATA_W-97 -: 16];
      end else if (eth_hdr_val && eth_hdr_rdy) begin
        eth_hdr_val <= 1'b0;
        eth_dst_mac <= '0;
        eth_src_mac <= '0;
        eth_type    <= '0;
      end
    end
  end

`ifdef ETH_RX_HDR_PARSER_STATS_EN
  logic runt_drop;
  logic [31:0] frame_cnt, runt_cnt;

  assign runt_drop = (state == HDR) && mac_engine_rx_val && engine_mac_rx_rdy && short_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      runt_cnt  <= '0;
    end else begin
      if (hdr_load)  frame_cnt <= frame_cnt + 32'd1;
      if (runt_drop) runt_cnt  <= runt_cnt + 32'd1;
    end
  end

  assign stat_frame_cnt = frame_cnt;
  assign stat_runt_cnt  = runt_cnt;
`else
  assign stat_frame_cnt = '0;
  assign stat_runt_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Directed bench for eth_rx_hdr_parser: frame table with scoreboarded payload plus reset corner cases.
module tb_eth_rx_hdr_parser;
`ifdef ETH_RX_HDR_PARSER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         mac_engine_rx_val;
  logic         engine_mac_rx_rdy;
  logic [255:0] mac_engine_rx_data;
  logic         mac_engine_rx_last;
  logic [4:0]   mac_engine_rx_padbytes;
  logic         eth_hdr_val;
  logic         eth_hdr_rdy;
  logic [47:0]  eth_dst_mac, eth_src_mac;
  logic [15:0]  eth_type;
  logic         eth_data_val;
  logic         eth_data_rdy;
  logic [255:0] eth_data;
  logic         eth_data_last;
  logic [4:0]   eth_data_padbytes;
  logic [31:0]  stat_frame_cnt, stat_runt_cnt;

  eth_rx_hdr_parser #(.DATA_W(256)) dut (
    .clk(clk), .rst(rst),
    .mac_engine_rx_val(mac_engine_rx_val), .engine_mac_rx_rdy(engine_mac_rx_rdy),
    .mac_engine_rx_data(mac_engine_rx_data), .mac_engine_rx_last(mac_engine_rx_last),
    .mac_engine_rx_padbytes(mac_engine_rx_padbytes),
    .eth_hdr_val(eth_hdr_val), .eth_hdr_rdy(eth_hdr_rdy),
    .eth_dst_mac(eth_dst_mac), .eth_src_mac(eth_src_mac), .eth_type(eth_type),
    .eth_data_val(eth_data_val), .eth_data_rdy(eth_data_rdy), .eth_data(eth_data),
    .eth_data_last(eth_data_last), .eth_data_padbytes(eth_data_padbytes),
    .stat_frame_cnt(stat_frame_cnt), .stat_runt_cnt(stat_runt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;       // input frame length in bytes
    int beats;     // expected payload beats
    int last_pad;  // expected padbytes on last payload beat
    bit runt;      // expected to be dropped
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [255:0] beat_q[$];
  bit           last_q[$];
  logic [4:0]   pad_q[$];
  logic [111:0] exp_hdr_q[$];
  logic [7:0]   exp_bytes[$];
  int           end_beats_q[$];
  int           end_pad_q[$];
  int           cur_beats = 0;
  int           hdr_hold = 0;
  bit           toggle = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic add_frame(input int len, input int seed, input int beats, input int lpad, input bit runt);
    logic [7:0]   f[$];
    logic [255:0] d;
    logic [111:0] h;
    int           nb;
    for (int i = 0; i < len; i++) f.push_back(8'(seed * 37 + i * 5 + 3));
    nb = (len + 31) / 32;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < 32; k++)
        d[255 - 8*k -: 8] = (b*32 + k < len) ? f[b*32 + k] : 8'hEE;
      beat_q.push_back(d);
      last_q.push_back(b == nb - 1);
      pad_q.push_back((b == nb - 1) ? 5'(nb*32 - len) : 5'd0);
    end
    if (!runt) begin
      for (int i = 0; i < 14; i++) h[111 - 8*i -: 8] = f[i];
      exp_hdr_q.push_back(h);
      for (int i = 14; i < len; i++) exp_bytes.push_back(f[i]);
      end_beats_q.push_back(beats);
      end_pad_q.push_back(lpad);
    end
  endtask

  task automatic cycle();
    logic [255:0] exp_vec;
    logic [7:0]   eb;
    bit           beat_bad;
    int           nb;
    @(negedge clk);
    if (beat_q.size() > 0) begin
      mac_engine_rx_val      = 1'b1;
      mac_engine_rx_data     = beat_q[0];
      mac_engine_rx_last     = last_q[0];
      mac_engine_rx_padbytes = pad_q[0];
    end else begin
      mac_engine_rx_val      = 1'b0;
      mac_engine_rx_data     = '0;
      mac_engine_rx_last     = 1'b0;
      mac_engine_rx_padbytes = '0;
    end
    if (hdr_hold > 0) begin
      eth_hdr_rdy = 1'b0;
      hdr_hold--;
    end else begin
      eth_hdr_rdy = 1'b1;
    end
    eth_data_rdy = toggle ? ~eth_data_rdy : 1'b1;
    #1;
    if (eth_hdr_val && eth_hdr_rdy) begin
      if (exp_hdr_q.size() == 0) chk("unexpected_hdr", 1, 0);
      else chk("header", {eth_dst_mac, eth_src_mac, eth_type}, exp_hdr_q.pop_front());
    end
    if (eth_data_val && eth_data_rdy) begin
      nb = eth_data_last ? 32 - int'(eth_data_padbytes) : 32;
      exp_vec  = '0;
      beat_bad = 1'b0;
      for (int k = 0; k < nb; k++) begin
        if (exp_bytes.size() == 0) begin
          beat_bad = 1'b1;
        end else begin
          eb = exp_bytes.pop_front();
          exp_vec[255 - 8*k -: 8] = eb;
          if (eth_data[255 - 8*k -: 8] !== eb) beat_bad = 1'b1;
        end
      end
      chk("payload", beat_bad ? eth_data : 256'd0, beat_bad ? exp_vec : 256'd0);
      cur_beats++;
      if (!eth_data_last) begin
        chk("mid_padbytes", eth_data_padbytes, 0);
      end else if (end_pad_q.size() == 0) begin
        chk("unexpected_last", 1, 0);
      end else begin
        chk("last_padbytes", eth_data_padbytes, end_pad_q.pop_front());
        chk("beat_count", cur_beats, end_beats_q.pop_front());
        cur_beats = 0;
      end
    end
    if (mac_engine_rx_val && engine_mac_rx_rdy) begin
      void'(beat_q.pop_front());
      void'(last_q.pop_front());
      void'(pad_q.pop_front());
    end
  endtask

  task automatic run(input string tag, input int budget);
    int cyc = 0;
    while ((beat_q.size() > 0 || exp_hdr_q.size() > 0 || exp_bytes.size() > 0 ||
            end_pad_q.size() > 0) && cyc < budget) begin
      cycle();
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL %s timeout: got %0d cycles want < %0d", tag, cyc, budget);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    mac_engine_rx_val = 1'b0;
    eth_data_rdy      = 1'b1;
    eth_hdr_rdy       = 1'b1;
    #1;
    chk({tag, "_idle_data_val"}, eth_data_val, 0);
    chk({tag, "_idle_hdr_val"}, eth_hdr_val, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    mac_engine_rx_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beat_q.delete(); last_q.delete(); pad_q.delete();
    exp_hdr_q.delete(); exp_bytes.delete(); end_beats_q.delete(); end_pad_q.delete();
    cur_beats = 0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{len: 60, beats: 2, last_pad: 18, runt: 1'b0};
    vecs[1] = '{len: 20, beats: 1, last_pad: 26, runt: 1'b0};
    vecs[2] = '{len: 14, beats: 0, last_pad: 0,  runt: 1'b1};
    vecs[3] = '{len: 46, beats: 1, last_pad: 0,  runt: 1'b0};

    rst = 1'b1;
    mac_engine_rx_val = 1'b0; mac_engine_rx_data = '0; mac_engine_rx_last = 1'b0;
    mac_engine_rx_padbytes = '0; eth_hdr_rdy = 1'b1; eth_data_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_hdr_val", eth_hdr_val, 0);
    chk("rst_data_val", eth_data_val, 0);
    chk("rst_hdr_fields", {eth_dst_mac, eth_src_mac, eth_type}, 0);
    chk("rst_frame_cnt", stat_frame_cnt, 0);
    chk("rst_runt_cnt", stat_runt_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      add_frame(vecs[i].len, i + 1, vecs[i].beats, vecs[i].last_pad, vecs[i].runt);
      run($sformatf("vec%0d", i), 50);
      idle_chk($sformatf("vec%0d", i));
    end
    chk("table_frame_cnt", stat_frame_cnt, STATS ? 3 : 0);
    chk("table_runt_cnt", stat_runt_cnt, STATS ? 1 : 0);

    // back-to-back frames, header consumer stalled, payload consumer toggling
    reset_dut();
    hdr_hold = 5;
    toggle   = 1'b1;
    for (int f = 0; f < 4; f++) add_frame(64, 10 + f, 2, 14, 1'b0);
    run("b2b", 200);
    toggle = 1'b0;
    idle_chk("b2b");
    chk("b2b_frame_cnt", stat_frame_cnt, STATS ? 4 : 0);
    chk("b2b_runt_cnt", stat_runt_cnt, 0);

    // reset asserted while the second beat of a frame is presented
    @(negedge clk);
    mac_engine_rx_val = 1'b1; mac_engine_rx_data = {8{32'h1234_5678}};
    mac_engine_rx_last = 1'b0; mac_engine_rx_padbytes = '0;
    eth_hdr_rdy = 1'b0; eth_data_rdy = 1'b0;
    #1;
    chk("mid_first_rdy", engine_mac_rx_rdy, 1);
    @(negedge clk);
    mac_engine_rx_data = {8{32'h9abc_def0}};
    mac_engine_rx_last = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_hdr_loaded", eth_hdr_val, 1);
    chk("mid_payload_val", eth_data_val, 1);
    @(negedge clk);
    rst = 1'b0;
    mac_engine_rx_val = 1'b0;
    #1;
    chk("mid_rst_hdr_val", eth_hdr_val, 0);
    chk("mid_rst_data_val", eth_data_val, 0);
    chk("mid_rst_rdy", engine_mac_rx_rdy, 1);
    chk("mid_rst_frame_cnt", stat_frame_cnt, 0);
    add_frame(20, 50, 1, 26, 1'b0);
    run("post_rst", 50);
    idle_chk("post_rst");
    chk("post_rst_frame_cnt", stat_frame_cnt, STATS ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
